// File: rtl/i2s_rx_frontend.sv
// ============================================================================
// Module      : i2s_rx_frontend
// Description : I2S slave receiver. Synchronizes sclk/ws/data into the clk
//               domain, frames left/right slots and presents truncated
//               OUT_W-bit stereo samples with a one-clk valid pulse.
//               Optional framing-error reporting (sync_err, err_cnt) is
//               enabled by defining the macro I2S_RX_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2s_rx_frontend #(
    parameter int SLOT_W    = 24,
    parameter int OUT_W     = 16,
    parameter int SLOT_CLKS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i2s_sclk,
    input  logic             i2s_ws,
    input  logic             i2s_data,
    output logic [OUT_W-1:0] lft_out,
    output logic [OUT_W-1:0] rght_out,
    output logic             vld
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic             sync_err,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [5:0] C_SLOT_END = 6'(SLOT_CLKS);
    localparam logic [5:0] C_LSB_IDX  = 6'(SLOT_W + 1);
    localparam logic [5:0] C_MSB_IDX  = 6'd2;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // Synchronizer chains; all three inputs see identical depth so they stay aligned
    logic [1:0]        r_sclk_sync;
    logic [1:0]        r_ws_sync;
    logic [1:0]        r_data_sync;
    logic              r_sclk_d;

    state_t            r_state;
    logic [5:0]        r_cnt;
    logic              r_ws_prev;
    logic [SLOT_W-1:0] r_left_sh;
    logic [SLOT_W-1:0] r_right_sh;
    logic              r_done;

    logic              w_ws_s;
    logic              w_data_s;
    logic              w_rise;
    logic              w_trans;
    logic [5:0]        w_cnt_inc;
    logic              w_at_end;
    logic              w_bit_slot;
    logic              w_err;

    assign w_ws_s     = r_ws_sync[1];
    assign w_data_s   = r_data_sync[1];
    assign w_rise     = r_sclk_sync[1] & ~r_sclk_d;
    assign w_trans    = w_ws_s ^ r_ws_prev;
    assign w_cnt_inc  = r_cnt + 6'd1;
    assign w_at_end   = (r_cnt == C_SLOT_END);
    // Index of the current rise is the incremented count; MSB sits at index 2
    assign w_bit_slot = (w_cnt_inc >= C_MSB_IDX) && (w_cnt_inc <= C_LSB_IDX);
    // Framing error: ws edge at the wrong place, or slot overran without an edge
    assign w_err      = w_rise && ((r_state == LEFT) || (r_state == RIGHT)) &&
                        (w_trans ? !w_at_end : w_at_end);

    // Two-flop synchronizers plus a delayed sclk copy for rise detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 2'b00;
            r_ws_sync   <= 2'b00;
            r_data_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i2s_sclk};
            r_ws_sync   <= {r_ws_sync[0], i2s_ws};
            r_data_sync <= {r_data_sync[0], i2s_data};
            r_sclk_d    <= r_sclk_sync[1];
        end
    end

    // Slot framing state machine, rise counter and per-channel shift registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SYNC;
            r_cnt      <= 6'd0;
            r_ws_prev  <= 1'b0;
            r_left_sh  <= '0;
            r_right_sh <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rise) begin
                r_ws_prev <= w_ws_s;
                r_cnt     <= w_trans ? 6'd1 : w_cnt_inc;
                case (r_state)
                    SYNC: begin
                        // Frames only ever start on a left slot
                        if (w_trans && !w_ws_s) begin
                            r_state <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (w_err) begin
                            r_state <= (w_trans && !w_ws_s) ? LEFT : SYNC;
                        end else if (w_trans) begin
                            r_state <= RIGHT;
                        end else if (w_bit_slot) begin
                            r_left_sh <= {r_left_sh[SLOT_W-2:0], w_data_s};
                        end
                    end
                    RIGHT: begin
                        if (w_err) begin
                            // A 1->0 error edge doubles as a fresh left-slot start
                            r_state <= (w_trans && !w_ws_s) ? LEFT : SYNC;
                        end else if (w_trans) begin
                            r_state <= LEFT;
                        end else if (w_bit_slot) begin
                            r_right_sh <= {r_right_sh[SLOT_W-2:0], w_data_s};
                            if (w_cnt_inc == C_LSB_IDX) begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= SYNC;
                    end
                endcase
            end
        end
    end

    // Output stage: one register after frame completion fixes the latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_out  <= '0;
            rght_out <= '0;
            vld      <= 1'b0;
        end else begin
            vld <= r_done;
            if (r_done) begin
                lft_out  <= r_left_sh[SLOT_W-1 -: OUT_W];
                rght_out <= r_right_sh[SLOT_W-1 -: OUT_W];
            end
        end
    end

`ifdef I2S_RX_ERR_CNT_EN
    // Framing-error pulse and saturating error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            sync_err <= w_err;
            if (w_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
